// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - raster-order minimum-SAD tracker with row/column of best match
//
// Scans one SAD result per candidate window position in row-major order and
// keeps the smallest SAD seen together with its (row, col). The best match is
// reported when the last position has been accepted.
//
// Optional feature macro: SAD_TIE_LAST_EN
//   undefined : strict '<' update, the first raster position of equal minima wins
//   defined   : '<=' update, the last raster position of equal minima wins
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   start      in   one-cycle pulse; begins a scan and samples cfg_rows/cfg_cols
//   cfg_rows   in   number of candidate rows
//   cfg_cols   in   number of candidate columns
//   sad_valid  in   sad_value carries the result for the current position
//   sad_value  in   SAD of the current candidate position
//   sad_ready  out  tracker accepts sad_value this cycle (decoded from state)
//   busy       out  scan in progress
//   done       out  scan complete, results valid; held until next start
//   min_sad    out  minimum SAD found
//   min_row    out  row of the minimum
//   min_col    out  column of the minimum

module sad_min_tracker #(
    parameter int COORD_W = 8,
    parameter int SAD_W   = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [COORD_W-1:0] cfg_rows,
    input  logic [COORD_W-1:0] cfg_cols,
    input  logic               sad_valid,
    input  logic [SAD_W-1:0]   sad_value,
    output logic               sad_ready,
    output logic               busy,
    output logic               done,
    output logic [SAD_W-1:0]   min_sad,
    output logic [COORD_W-1:0] min_row,
    output logic [COORD_W-1:0] min_col
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] COORD_ZERO = '0;

    state_t             state;
    logic [COORD_W-1:0] rows_q;
    logic [COORD_W-1:0] cols_q;
    logic [COORD_W-1:0] row_cnt;
    logic [COORD_W-1:0] col_cnt;
    logic               first_q;

    logic               accept;
    logic               last_col;
    logic               last_row;
    logic               better;
    logic               take;
    logic               zero_dim;

    // Ready comes straight from the state register so the upstream datapath
    // never sees a combinational path from its own valid back to ready.
    assign sad_ready = (state == ST_SCAN);
    assign accept    = sad_valid && sad_ready;

    // Dimensions are known non-zero while scanning, so the -1 cannot wrap.
    assign last_col  = (col_cnt == (cols_q - COORD_ONE));
    assign last_row  = (row_cnt == (rows_q - COORD_ONE));
    assign zero_dim  = (cfg_rows == COORD_ZERO) || (cfg_cols == COORD_ZERO);

`ifdef SAD_TIE_LAST_EN
    assign better    = (sad_value <= min_sad);
`else
    assign better    = (sad_value < min_sad);
`endif

    // The first sample loads unconditionally so an all-ones SAD still
    // records its coordinates instead of leaving stale ones from a prior scan.
    assign take      = first_q || better;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            first_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            min_sad <= '1;
            min_row <= '0;
            min_col <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rows_q  <= cfg_rows;
                        cols_q  <= cfg_cols;
                        row_cnt <= '0;
                        col_cnt <= '0;
                        if (zero_dim) begin
                            // Empty search area: report the "nothing found"
                            // result immediately without entering SCAN.
                            state   <= ST_DONE;
                            first_q <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            min_sad <= '1;
                            min_row <= '0;
                            min_col <= '0;
                        end else begin
                            state   <= ST_SCAN;
                            first_q <= 1'b1;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end

                ST_SCAN: begin
                    // start is deliberately ignored while a scan is running.
                    if (accept) begin
                        first_q <= 1'b0;
                        if (take) begin
                            min_sad <= sad_value;
                            min_row <= row_cnt;
                            min_col <= col_cnt;
                        end
                        if (last_col) begin
                            col_cnt <= '0;
                            if (last_row) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + COORD_ONE;
                            end
                        end else begin
                            col_cnt <= col_cnt + COORD_ONE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb/tb_sad_min_tracker.sv - self-checking bench for sad_min_tracker against a raster-list model
module tb_sad_min_tracker;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [7:0]  cfg_rows;
    logic [7:0]  cfg_cols;
    logic        sad_valid;
    logic [31:0] sad_value;
    logic        sad_ready;
    logic        busy;
    logic        done;
    logic [31:0] min_sad;
    logic [7:0]  min_row;
    logic [7:0]  min_col;

    int checks = 0;
    int errors = 0;

    sad_min_tracker #(.COORD_W(8), .SAD_W(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .cfg_rows  (cfg_rows),
        .cfg_cols  (cfg_cols),
        .sad_valid (sad_valid),
        .sad_value (sad_value),
        .sad_ready (sad_ready),
        .busy      (busy),
        .done      (done),
        .min_sad   (min_sad),
        .min_row   (min_row),
        .min_col   (min_col)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: the accepted SADs of the current scan kept as a plain raster list;
    // the best entry's index maps to (index / cols, index % cols).
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_rows   = 0;
    int          m_cols   = 0;
    logic [31:0] m_acc[$];
    logic [31:0] h_sad    = 32'hFFFF_FFFF;
    int          h_row    = 0;
    int          h_col    = 0;

    task automatic model_min(output logic [31:0] s, output int r, output int c);
        int bi;
        if (m_acc.size() == 0) begin
            s = h_sad; r = h_row; c = h_col;
        end else begin
            bi = 0;
            for (int i = 1; i < m_acc.size(); i++) begin
`ifdef SAD_TIE_LAST_EN
                if (m_acc[i] <= m_acc[bi]) bi = i;
`else
                if (m_acc[i] < m_acc[bi]) bi = i;
`endif
            end
            s = m_acc[bi]; r = bi / m_cols; c = bi % m_cols;
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0;
        m_acc.delete();
        h_sad = 32'hFFFF_FFFF; h_row = 0; h_col = 0;
    endtask

    always @(negedge Clk) begin
        logic [31:0] es;
        int er, ec;
        if (!Reset) model_reset();
        model_min(es, er, ec);
        check("sad_ready", {63'd0, sad_ready}, {63'd0, m_active});
        check("busy",      {63'd0, busy},      {63'd0, m_active});
        check("done",      {63'd0, done},      {63'd0, m_done});
        check("min_sad",   {32'd0, min_sad},   {32'd0, es});
        check("min_row",   {56'd0, min_row},   64'(er));
        check("min_col",   {56'd0, min_col},   64'(ec));
        if (Reset) begin
            if (start && !m_active) begin
                model_min(h_sad, h_row, h_col);
                m_acc.delete();
                m_rows = int'(cfg_rows); m_cols = int'(cfg_cols);
                if (m_rows == 0 || m_cols == 0) begin
                    m_active = 1'b0; m_done = 1'b1;
                    h_sad = 32'hFFFF_FFFF; h_row = 0; h_col = 0;
                end else begin
                    m_active = 1'b1; m_done = 1'b0;
                end
            end else if (m_active && sad_valid) begin
                m_acc.push_back(sad_value);
                if (m_acc.size() == m_rows * m_cols) begin
                    m_active = 1'b0; m_done = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input int r, input int c);
        cfg_rows = 8'(r); cfg_cols = 8'(c); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        sad_valid = 1'b1; sad_value = v;
        step();
        sad_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] s, input int r, input int c);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_sad"},  {32'd0, min_sad}, {32'd0, s});
        check({tag, "_row"},  {56'd0, min_row}, 64'(r));
        check({tag, "_col"},  {56'd0, min_col}, 64'(c));
    endtask

    initial begin
        int r, c, n, cyc;
        Reset = 1'b0; start = 1'b0; cfg_rows = '0; cfg_cols = '0;
        sad_valid = 1'b0; sad_value = '0;
        step(); step();
        check("rst_min_sad", {32'd0, min_sad}, 64'hFFFF_FFFF);
        check("rst_done", {63'd0, done}, 64'd0);
        Reset = 1'b1;
        step();

        // Basic 2x3
        do_start(2, 3);
        send(50); send(40); send(70); send(30); send(90);
        check("basic_not_done_yet", {63'd0, done}, 64'd0);
        send(60);
        expect_result("basic", 32'd30, 1, 0);
        step();

        // Ties 2x2
        do_start(2, 2);
        send(10); send(5); send(5); send(8);
`ifdef SAD_TIE_LAST_EN
        expect_result("tie", 32'd5, 1, 0);
`else
        expect_result("tie", 32'd5, 0, 1);
`endif

        // Bubbles with start mid-scan, 1x4
        do_start(1, 4);
        send(9);
        cfg_rows = 8'd3; cfg_cols = 8'd3; start = 1'b1; sad_value = 32'd1; step(); start = 1'b0;
        send(7);
        sad_value = 32'd0; step();
        send(7);
        check("bubble_still_busy", {63'd0, busy}, 64'd1);
        send(2);
        expect_result("bubble", 32'd2, 0, 3);

        // All-ones first sample, 1x2
        do_start(1, 2);
        send(32'hFFFF_FFFF); send(32'hFFFF_FFFF);
        expect_result("ones", 32'hFFFF_FFFF, 0, 0);

        // Zero dimension
        sad_valid = 1'b1; sad_value = 32'd3;
        do_start(0, 5);
        check("zero_ready", {63'd0, sad_ready}, 64'd0);
        expect_result("zero", 32'hFFFF_FFFF, 0, 0);
        step();
        sad_valid = 1'b0;
        check("zero_hold", {63'd0, done}, 64'd1);

        // Reset mid-scan, between edges
        do_start(2, 3);
        send(20); send(15); send(25);
        #2 Reset = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_ready", {63'd0, sad_ready}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_sad", {32'd0, min_sad}, 64'hFFFF_FFFF);
        check("arst_row", {56'd0, min_row}, 64'd0);
        step();
        Reset = 1'b1;
        step();
        do_start(1, 1);
        send(12);
        expect_result("after_rst", 32'd12, 0, 0);

        // Randomized scans, checked every cycle by the model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(1, 4);
            c = $urandom_range(1, 5);
            if ($urandom_range(0, 9) == 0) r = 0;
            do_start(r, c);
            cyc = 0;
            while (!done && cyc < 400) begin
                sad_valid = ($urandom_range(0, 3) != 0);
                n = $urandom_range(0, 7);
                sad_value = (n == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
                start = ($urandom_range(0, 15) == 0);
                cfg_rows = 8'($urandom_range(0, 3));
                step();
                start = 1'b0;
                cyc++;
            end
            sad_valid = 1'b0;
            if (cyc >= 400) begin
                errors++;
                $display("FAIL rand_timeout actual=busy expected=done");
            end
            if ($urandom_range(0, 2) == 0) step();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
